alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- multi-cycle integer execute unit with request/result handshakes.
//
// Decodes a RISC-V style (aluop, funct3, funct7b5, funct7b0, op5) request into
// a 4-bit operation code and executes it. There is one operation in flight at
// a time.
//   - Simple ALU operations complete on the accepting edge.
//   - Shifts iterate by up to SHIFT_STEP bit positions per cycle.
//   - The optional multiply uses shift-add.
//
// Optional feature: define ALU_EXEC_MUL_EN to build in the iterative multiplier.
// This adds the MUL state and operation code 1010.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready only while idle)
//   aluop, funct3, funct7b5, funct7b0, op5   operation encoding
//   src_a, src_b          XLEN-bit operands
//   out_valid / out_ready result handshake
//   result, zero          result and (result == 0), registered together
//   alu_ctrl              decoded code of the current/last request
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl
);
  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [1:0] S_MUL   = 2'd3;
`endif

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f7b5, input logic f7b0, input logic o5);
    logic [3:0] c;
    c = OP_ADD;
    case (op)
      2'b01: begin
        case (f3)
          3'b100, 3'b101: c = OP_SLT;
          3'b110, 3'b111: c = OP_SLTU;
          default:        c = OP_SUB;
        endcase
      end
      2'b10: begin
        case (f3)
          3'b000:  c = (o5 & f7b5) ? OP_SUB : OP_ADD;
          3'b001:  c = OP_SLL;
          3'b010:  c = OP_SLT;
          3'b011:  c = OP_SLTU;
          3'b100:  c = OP_XOR;
          3'b101:  c = f7b5 ? OP_SRA : OP_SRL;
          3'b110:  c = OP_OR;
          default: c = OP_AND;
        endcase
`ifdef ALU_EXEC_MUL_EN
        if (f3 == 3'b000 && o5 && f7b0) c = OP_MUL;
`endif
      end
      default: c = OP_ADD;
    endcase
`ifndef ALU_EXEC_MUL_EN
    // funct7b0 only selects MUL; without the multiplier it has no effect.
    if (f7b0) c = c;
`endif
    return c;
  endfunction

  function automatic logic [XLEN-1:0] alu_simple(input logic [3:0] c, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (c)
      OP_SUB:  return a - b;
      OP_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] shift_by(input logic [3:0] c, input logic [XLEN-1:0] v,
                                               input logic [SW-1:0] n);
    logic signed [XLEN-1:0] sv;
    sv = v;
    case (c)
      OP_SLL:  return v << n;
      OP_SRL:  return v >> n;
      // Shifting the partial result keeps its MSB equal to the original src_a MSB.
      OP_SRA:  return sv >>> n;
      default: return v;
    endcase
  endfunction

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [3:0]      dec;
  logic [SW-1:0]   shamt_in, amt_in, amt;
`ifdef ALU_EXEC_MUL_EN
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_EXEC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    dec      = decode(aluop, funct3, funct7b5, funct7b0, op5);
    shamt_in = src_b[SW-1:0];
    amt_in   = (shamt_in > STEP) ? STEP : shamt_in;
    amt      = (cnt_q > STEP) ? STEP : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ctrl_d = dec;
          case (dec)
            // The first shift step happens on the accepting edge, so a shift of
            // n positions finishes after ceil(n/SHIFT_STEP) edges (min 1).
            OP_SLL, OP_SRL, OP_SRA: begin
              result_d = shift_by(dec, src_a, amt_in);
              cnt_d    = shamt_in - amt_in;
              state_d  = (cnt_d == '0) ? S_DONE : S_SHIFT;
            end
`ifdef ALU_EXEC_MUL_EN
            // Bit 0 of the multiplier is consumed on the accepting edge and the
            // remaining XLEN-1 bits are consumed in MUL: XLEN edges in total.
            OP_MUL: begin
              result_d = src_b[0] ? src_a : '0;
              mcand_d  = src_a << 1;
              mplier_d = src_b >> 1;
              cnt_d    = SW'(XLEN - 1);
              state_d  = S_MUL;
            end
`endif
            default: begin
              result_d = alu_simple(dec, src_a, src_b);
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_SHIFT: begin
        result_d = shift_by(ctrl_q, result_q, amt);
        cnt_d    = cnt_q - amt;
        if (cnt_d == '0) state_d = S_DONE;
      end
`ifdef ALU_EXEC_MUL_EN
      S_MUL: begin
        result_d = result_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SW'(1)) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // zero is captured together with the final result value.
    if (state_d == S_DONE && state_q != S_DONE) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ctrl_q   <= OP_ADD;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_EXEC_MUL_EN
  // Multiplier working registers are only meaningful inside MUL, so they carry no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign alu_ctrl  = ctrl_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int XLEN = 32;
  localparam int STEP = 4;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_SLL = 4'd2, C_SLT = 4'd3,
                         C_SLTU = 4'd4, C_XOR = 4'd5, C_SRL = 4'd6, C_SRA = 4'd7,
                         C_OR = 4'd8, C_AND = 4'd9, C_MUL = 4'd10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      aluop = '0;
  logic [2:0]      funct3 = '0;
  logic            funct7b5 = 1'b0, funct7b0 = 1'b0, op5 = 1'b0;
  logic [XLEN-1:0] src_a = '0, src_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_ctrl;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .op5(op5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .alu_ctrl(alu_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: operation table, plain arithmetic and a latency rule.
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                          input logic f7b5, input logic f7b0, input logic o5);
    logic [3:0] tab [8];
    tab = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
    if (op == 2'b00 || op == 2'b11) return C_ADD;
    if (op == 2'b01) begin
      if (f3 == 3'd4 || f3 == 3'd5) return C_SLT;
      if (f3 == 3'd6 || f3 == 3'd7) return C_SLTU;
      return C_SUB;
    end
    if (MUL_EN && f3 == 3'd0 && o5 && f7b0) return C_MUL;
    if (f3 == 3'd0 && o5 && f7b5) return C_SUB;
    if (f3 == 3'd5 && f7b5) return C_SRA;
    return tab[f3];
  endfunction

  function automatic logic [XLEN-1:0] ref_result(input logic [3:0] c, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    int sh;
    logic signed [XLEN-1:0] sa;
    sh = int'(b % XLEN);
    sa = a;
    case (c)
      C_ADD:  return a + b;
      C_SUB:  return a - b;
      C_SLL:  return a << sh;
      C_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      C_SLTU: return (a < b) ? 1 : 0;
      C_XOR:  return a ^ b;
      C_SRL:  return a >> sh;
      C_SRA:  return sa >>> sh;
      C_OR:   return a | b;
      C_AND:  return a & b;
      default: return XLEN'(64'(a) * 64'(b));
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b % XLEN);
    if (c == C_MUL) return XLEN;
    if (c == C_SLL || c == C_SRL || c == C_SRA) return (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
    return 1;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                        input logic f7b0, input logic o5, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int hold);
    logic [3:0] ec;
    logic [XLEN-1:0] er;
    int elat, lat;
    ec   = ref_ctrl(op, f3, f7b5, f7b0, o5);
    er   = ref_result(ec, a, b);
    elat = ref_lat(ec, b);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    aluop = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; op5 = o5;
    src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    aluop = 2'($urandom); funct3 = 3'($urandom); src_a = $urandom; src_b = $urandom;
    funct7b5 = 1'($urandom); funct7b0 = 1'($urandom); op5 = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < XLEN + 8) begin
      chk("in_ready_busy", 64'(in_ready), 64'(0));
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("result", 64'(result), 64'(er));
    chk("zero", 64'(zero), 64'(er == '0));
    chk("alu_ctrl", 64'(alu_ctrl), 64'(ec));
    chk("in_ready_done", 64'(in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(result), 64'(er));
      chk("hold_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 64'(out_valid), 64'(0));
    chk("post_hs_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int stale;
    #3 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // SUB via funct7b5: 5 - 7
    run_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 0);
    // Branch SUB equal operands, result held 3 cycles
    run_op(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 3);
    // SRA / SRL by 9, shamt 0
    run_op(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd9, 0);
    run_op(2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd9, 0);
    run_op(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8765_4321, 32'd32, 1);
    run_op(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'd31, 0);
    // SLT / SLTU signedness
    run_op(2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    // Multiply encoding (ADD without the multiplier)
    run_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3, 0);
    // aluop 00 / 11 always ADD
    run_op(2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(2'b11, 3'b101, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    // Reset in the middle of a long shift
    @(negedge clk);
    aluop = 2'b10; funct3 = 3'b101; funct7b5 = 1'b1; funct7b0 = 1'b0; op5 = 1'b0;
    src_a = 32'hC000_0000; src_b = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_shift_valid", 64'(out_valid), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_alu_ctrl", 64'(alu_ctrl), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    out_ready = 1'b0;
    chk("no_stale_result", 64'(stale), 64'(0));
    chk("ready_after_abort", 64'(in_ready), 64'(1));

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      logic [XLEN-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 7 == 0) rb = ra;
      if (n % 5 == 0) rb = XLEN'($urandom_range(0, 40));
      run_op(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ra, rb, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
